// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: byte FIFO, flow control and parity-error backoff
module uart_rx_ctrl #(
    parameter int DEPTH   = 4,
    parameter int BACKOFF = 2500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     rx_ready,
    input  logic [7:0]               rx_byte,
    input  logic                     error_led1,
    input  logic                     error_led2,
    output logic                     rec_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               perr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] BOFF_LD  = CW'(BACKOFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LISTEN,
        ST_HOLD,
        ST_FULL,
        ST_BACKOFF
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_rec_ready;
    logic           r_rx_prev;
    logic [CW-1:0]  r_boff_cnt;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_overflow;
    logic [7:0]     r_perr;
    logic [7:0]     r_mem [DEPTH];

    logic w_rise;
    logic w_perr;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;

    assign w_rise = rx_ready && !r_rx_prev;
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = out_ack && (r_count != '0);

    // A parity error outranks a frame edge arriving in the same cycle.
    assign w_perr = enable && (r_state != ST_IDLE) && (error_led1 || error_led2);

    // A frame edge while FULL is still an attempted push; it is dropped unless a pop frees the slot.
    assign w_push_req = enable && !w_perr && w_rise &&
                        ((r_state == ST_LISTEN) || (r_state == ST_HOLD) || (r_state == ST_FULL));
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else if (w_perr) begin
            w_next = ST_BACKOFF;
        end else begin
            case (r_state)
                ST_IDLE:    w_next = w_full ? ST_FULL : ST_LISTEN;
                ST_LISTEN:  if (w_rise) w_next = ST_HOLD;
                ST_HOLD:    if (!rx_ready) w_next = w_full ? ST_FULL : ST_LISTEN;
                ST_FULL:    if (!w_full) w_next = ST_LISTEN;
                ST_BACKOFF: if (r_boff_cnt == '0) w_next = w_full ? ST_FULL : ST_LISTEN;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rec_ready <= 1'b0;
            r_rx_prev   <= 1'b0;
            r_boff_cnt  <= '0;
        end else begin
            r_state     <= w_next;
            r_rec_ready <= (w_next == ST_LISTEN);
            r_rx_prev   <= rx_ready;
            if (w_perr) begin
                r_boff_cnt <= BOFF_LD;
            end else if ((r_state == ST_BACKOFF) && (r_boff_cnt != '0)) begin
                r_boff_cnt <= r_boff_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_perr     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) r_overflow <= 1'b1;
            if (w_perr && (r_perr != 8'hFF)) r_perr <= r_perr + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= rx_byte;
    end

    assign rec_ready  = r_rec_ready;
    assign out_valid  = (r_count != '0);
    assign out_data   = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign perr_count = r_perr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       error_led1 = 1'b0;
    logic       error_led2 = 1'b0;
    logic       out_ack = 1'b0;
    logic       rec_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] perr_count;

    int checks = 0;
    int failures = 0;

    uart_rx_ctrl #(.DEPTH(4), .BACKOFF(2500)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rx_ready   (rx_ready),
        .rx_byte    (rx_byte),
        .error_led1 (error_led1),
        .error_led2 (error_led2),
        .rec_ready  (rec_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ack    (out_ack),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .perr_count (perr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        rx_ready = 1'b0;
        out_ack = 1'b0;
        tick();
        rst = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input int hold);
        rx_byte = b;
        rx_ready = 1'b1;
        repeat (hold) tick();
        rx_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_listen(input string name);
        int n;
        n = 0;
        while (rec_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (rec_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout rec_ready=%b required=1", name, rec_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (rec_ready !== 1'b0) begin failures++; $display("FAIL reset_rec_ready got=%b exp=0", rec_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (perr_count !== 8'd0) begin failures++; $display("FAIL reset_perr got=%0d exp=0", perr_count); end
        tick();
        checks++; if (rec_ready !== 1'b0) begin failures++; $display("FAIL idle_rec_ready got=%b exp=0", rec_ready); end
        enable = 1'b1;
        tick();
        checks++; if (rec_ready !== 1'b1) begin failures++; $display("FAIL listen_rec_ready got=%b exp=1", rec_ready); end
    endtask

    task automatic test_single_byte();
        rx_byte = 8'h41;
        rx_ready = 1'b1;
        tick();
        rx_byte = 8'h99;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'h41) begin failures++; $display("FAIL single_data got=%h exp=41", out_data); end
        checks++; if (rec_ready !== 1'b0) begin failures++; $display("FAIL single_hold_rec_ready got=%b exp=0", rec_ready); end
        repeat (1249) tick();
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_held_count got=%0d exp=1", fifo_count); end
        rx_ready = 1'b0;
        tick();
        tick();
        checks++; if (rec_ready !== 1'b1) begin failures++; $display("FAIL single_relisten got=%b exp=1", rec_ready); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_after_count got=%0d exp=1", fifo_count); end
        enable = 1'b0;
        tick();
        checks++; if (rec_ready !== 1'b0) begin failures++; $display("FAIL disable_rec_ready got=%b exp=0", rec_ready); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL disable_keeps_count got=%0d exp=1", fifo_count); end
        enable = 1'b1;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 10);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", fifo_count); end
        checks++; if (rec_ready !== 1'b0) begin failures++; $display("FAIL fill_rec_ready got=%b exp=0", rec_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_no_overflow got=%b exp=0", overflow); end
        send_frame(8'h05, 10);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_drop_count got=%0d exp=4", fifo_count); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_data !== 8'(i)) begin failures++; $display("FAIL fill_pop_data got=%h exp=%h", out_data, 8'(i)); end
            out_ack = 1'b1;
            tick();
            out_ack = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", out_valid); end
        tick();
        tick();
        checks++; if (rec_ready !== 1'b1) begin failures++; $display("FAIL fill_relisten got=%b exp=1", rec_ready); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_parity();
        int lows;
        error_led2 = 1'b1;
        tick();
        error_led2 = 1'b0;
        checks++; if (perr_count !== 8'd1) begin failures++; $display("FAIL parity_count got=%0d exp=1", perr_count); end
        lows = 0;
        while (rec_ready === 1'b0 && lows < 3000) begin
            lows++;
            tick();
        end
        checks++; if (lows !== 2500) begin failures++; $display("FAIL parity_backoff_cycles got=%0d exp=2500", lows); end
        checks++; if (rec_ready !== 1'b1) begin failures++; $display("FAIL parity_resume got=%b exp=1", rec_ready); end
    endtask

    task automatic test_collision();
        rx_byte = 8'h77;
        rx_ready = 1'b1;
        error_led1 = 1'b1;
        tick();
        error_led1 = 1'b0;
        rx_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL collision_count got=%0d exp=0", fifo_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL collision_valid got=%b exp=0", out_valid); end
        checks++; if (perr_count !== 8'd2) begin failures++; $display("FAIL collision_perr got=%0d exp=2", perr_count); end
        wait_listen("collision");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 5);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL b2b_full got=%0d exp=4", fifo_count); end
        rx_byte = 8'h14;
        rx_ready = 1'b1;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        rx_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL b2b_order got=%h exp=%h", out_data, 8'h10 + 8'(i)); end
            out_ack = 1'b1;
            tick();
            out_ack = 1'b0;
        end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        send_frame(8'hA1, 5);
        rx_byte = 8'hA2;
        rx_ready = 1'b1;
        tick();
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL hold_count got=%0d exp=2", fifo_count); end
        rst = 1'b1;
        rx_ready = 1'b0;
        tick();
        checks++; if (rec_ready !== 1'b0) begin failures++; $display("FAIL hold_rst_rec_ready got=%b exp=0", rec_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL hold_rst_data got=%h exp=00", out_data); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL hold_rst_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL hold_rst_overflow got=%b exp=0", overflow); end
        checks++; if (perr_count !== 8'd0) begin failures++; $display("FAIL hold_rst_perr got=%0d exp=0", perr_count); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill();
        test_parity();
        test_collision();
        test_back_to_back();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
